// File: rtl/sin_gen_pkg.sv
// sin_gen_pkg: shared constants and the FSM state type for the
// DDS sample generator (sin_lut, sin_sample_gen).
package sin_gen_pkg;

   localparam int DW     = 12;
   localparam int DEPTH  = 256;
   localparam int QDEPTH = 65;
   localparam int OFFSET = 2047;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      HOLD
   } state_t;

endpackage

// File: rtl/sin_lut.sv
// sin_lut: combinational sine ROM, offset-binary 12-bit codes.
// Ports: addr (8-bit phase index) in, code (DW) out.
// Macro SIN_QUARTER_LUT_EN: 65-entry quarter table + symmetry fold;
// undefined: full 256-entry table. Both give identical codes.
module sin_lut
   import sin_gen_pkg::*;
(
   input  logic [7:0]    addr,
   output logic [DW-1:0] code
);

`ifdef SIN_QUARTER_LUT_EN

   localparam logic [DW-1:0] QTAB [0:QDEPTH-1] = '{
      12'd0,    12'd50,   12'd100,  12'd151,
      12'd201,  12'd251,  12'd300,  12'd350,
      12'd399,  12'd449,  12'd497,  12'd546,
      12'd594,  12'd642,  12'd690,  12'd737,
      12'd783,  12'd830,  12'd875,  12'd920,
      12'd965,  12'd1009, 12'd1052, 12'd1095,
      12'd1137, 12'd1179, 12'd1219, 12'd1259,
      12'd1299, 12'd1337, 12'd1375, 12'd1411,
      12'd1447, 12'd1483, 12'd1517, 12'd1550,
      12'd1582, 12'd1614, 12'd1644, 12'd1674,
      12'd1702, 12'd1729, 12'd1756, 12'd1781,
      12'd1805, 12'd1828, 12'd1850, 12'd1871,
      12'd1891, 12'd1910, 12'd1927, 12'd1944,
      12'd1959, 12'd1973, 12'd1986, 12'd1997,
      12'd2008, 12'd2017, 12'd2025, 12'd2032,
      12'd2037, 12'd2041, 12'd2045, 12'd2046,
      12'd2047
   };

   logic [6:0]    idx;
   logic          neg;
   logic [DW-1:0] mag;

   // Fold the 256-point circle onto the first quadrant:
   // mirror in quadrants 1/3, negate in the lower half.
   always_comb begin
      idx = '0;
      neg = 1'b0;
      unique case (1'b1)
         (addr <= 8'd64): begin
            idx = addr[6:0];
         end
         (addr >= 8'd65 && addr <= 8'd128): begin
            idx = 7'(8'd128 - addr);
         end
         (addr >= 8'd129 && addr <= 8'd192): begin
            idx = 7'(addr - 8'd128);
            neg = 1'b1;
         end
         default: begin
            idx = 7'(9'd256 - {1'b0, addr});
            neg = 1'b1;
         end
      endcase
   end

   assign mag  = QTAB[idx];
   assign code = neg ? DW'(OFFSET) - mag
                     : DW'(OFFSET) + mag;

`else

   localparam logic [DW-1:0] FULL [0:DEPTH-1] = '{
      12'd2047, 12'd2097, 12'd2147, 12'd2198,
      12'd2248, 12'd2298, 12'd2347, 12'd2397,
      12'd2446, 12'd2496, 12'd2544, 12'd2593,
      12'd2641, 12'd2689, 12'd2737, 12'd2784,
      12'd2830, 12'd2877, 12'd2922, 12'd2967,
      12'd3012, 12'd3056, 12'd3099, 12'd3142,
      12'd3184, 12'd3226, 12'd3266, 12'd3306,
      12'd3346, 12'd3384, 12'd3422, 12'd3458,
      12'd3494, 12'd3530, 12'd3564, 12'd3597,
      12'd3629, 12'd3661, 12'd3691, 12'd3721,
      12'd3749, 12'd3776, 12'd3803, 12'd3828,
      12'd3852, 12'd3875, 12'd3897, 12'd3918,
      12'd3938, 12'd3957, 12'd3974, 12'd3991,
      12'd4006, 12'd4020, 12'd4033, 12'd4044,
      12'd4055, 12'd4064, 12'd4072, 12'd4079,
      12'd4084, 12'd4088, 12'd4092, 12'd4093,
      12'd4094, 12'd4093, 12'd4092, 12'd4088,
      12'd4084, 12'd4079, 12'd4072, 12'd4064,
      12'd4055, 12'd4044, 12'd4033, 12'd4020,
      12'd4006, 12'd3991, 12'd3974, 12'd3957,
      12'd3938, 12'd3918, 12'd3897, 12'd3875,
      12'd3852, 12'd3828, 12'd3803, 12'd3776,
      12'd3749, 12'd3721, 12'd3691, 12'd3661,
      12'd3629, 12'd3597, 12'd3564, 12'd3530,
      12'd3494, 12'd3458, 12'd3422, 12'd3384,
      12'd3346, 12'd3306, 12'd3266, 12'd3226,
      12'd3184, 12'd3142, 12'd3099, 12'd3056,
      12'd3012, 12'd2967, 12'd2922, 12'd2877,
      12'd2830, 12'd2784, 12'd2737, 12'd2689,
      12'd2641, 12'd2593, 12'd2544, 12'd2496,
      12'd2446, 12'd2397, 12'd2347, 12'd2298,
      12'd2248, 12'd2198, 12'd2147, 12'd2097,
      12'd2047, 12'd1997, 12'd1947, 12'd1896,
      12'd1846, 12'd1796, 12'd1747, 12'd1697,
      12'd1648, 12'd1598, 12'd1550, 12'd1501,
      12'd1453, 12'd1405, 12'd1357, 12'd1310,
      12'd1264, 12'd1217, 12'd1172, 12'd1127,
      12'd1082, 12'd1038, 12'd995,  12'd952,
      12'd910,  12'd868,  12'd828,  12'd788,
      12'd748,  12'd710,  12'd672,  12'd636,
      12'd600,  12'd564,  12'd530,  12'd497,
      12'd465,  12'd433,  12'd403,  12'd373,
      12'd345,  12'd318,  12'd291,  12'd266,
      12'd242,  12'd219,  12'd197,  12'd176,
      12'd156,  12'd137,  12'd120,  12'd103,
      12'd88,   12'd74,   12'd61,   12'd50,
      12'd39,   12'd30,   12'd22,   12'd15,
      12'd10,   12'd6,    12'd2,    12'd1,
      12'd0,    12'd1,    12'd2,    12'd6,
      12'd10,   12'd15,   12'd22,   12'd30,
      12'd39,   12'd50,   12'd61,   12'd74,
      12'd88,   12'd103,  12'd120,  12'd137,
      12'd156,  12'd176,  12'd197,  12'd219,
      12'd242,  12'd266,  12'd291,  12'd318,
      12'd345,  12'd373,  12'd403,  12'd433,
      12'd465,  12'd497,  12'd530,  12'd564,
      12'd600,  12'd636,  12'd672,  12'd710,
      12'd748,  12'd788,  12'd828,  12'd868,
      12'd910,  12'd952,  12'd995,  12'd1038,
      12'd1082, 12'd1127, 12'd1172, 12'd1217,
      12'd1264, 12'd1310, 12'd1357, 12'd1405,
      12'd1453, 12'd1501, 12'd1550, 12'd1598,
      12'd1648, 12'd1697, 12'd1747, 12'd1796,
      12'd1846, 12'd1896, 12'd1947, 12'd1997
   };

   assign code = FULL[addr];

`endif

endmodule

// File: rtl/sin_sample_gen.sv
// sin_sample_gen: DDS sine sample source with valid/ready output.
// Ports: clk_i, rst_i (async active-low), en_i, fcw_i (PW) in;
// sample_o (DW), valid_o, underrun_o out; ready_i in.
// Table build selected by SIN_QUARTER_LUT_EN (see sin_lut).
module sin_sample_gen
   import sin_gen_pkg::state_t,
          sin_gen_pkg::IDLE,
          sin_gen_pkg::ADDR,
          sin_gen_pkg::HOLD;
#(
   parameter int DW  = 12,
   parameter int PW  = 16,
   parameter int DIV = 1000
)
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic [PW-1:0] fcw_i,
   output logic [DW-1:0] sample_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic          underrun_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic          tick;
   logic [PW-1:0] phase;
   logic [7:0]    addr;
   logic [DW-1:0] rom_code;
   logic          load;
   logic          hs;
   state_t        state;
   state_t        state_nxt;

   assign tick = en_i && (cnt == CW'(DIV - 1));
   assign hs   = valid_o && ready_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt <= '0;
      end else if (!en_i || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Phase advances on every tick, even when the sample
   // is dropped, so the output frequency stays exact.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         phase <= '0;
         addr  <= '0;
      end else if (tick) begin
         addr  <= phase[PW-1 -: 8];
         phase <= phase + fcw_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      load       = 1'b0;
      underrun_o = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick) begin
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            load      = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (hs) begin
               state_nxt = tick ? ADDR : IDLE;
            end else if (tick) begin
               underrun_o = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sample_o <= '0;
      end else if (load) begin
         sample_o <= rom_code;
      end
   end

   // Decoded from the state register only; ready_i
   // never reaches valid_o combinationally.
   assign valid_o = (state == HOLD);

   sin_lut u_lut (
      .addr (addr),
      .code (rom_code)
   );

endmodule
